// File: rtl/booth4_mul_engine.sv
// booth4_mul_engine: radix-4 Booth multiplier streaming operand pairs from two FIFOs into a result FIFO.
// Optional MUL_ZERO_SKIP_EN: a pair with a zero operand bypasses EXEC and writes 0.
module booth4_mul_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic               signed_mode,
    input  logic [CNT_W-1:0]   fifo_count0,
    input  logic [CNT_W-1:0]   fifo_count1,
    input  logic               out_full,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               fifo_re,
    output logic               fifo_we,
    output logic [2*WIDTH-1:0] din_result,
    output logic               op_done,
    output logic               op_err
);
    localparam int HW = WIDTH + 3;
    localparam int LW = WIDTH + 2;
    localparam int AW = HW + LW;
    localparam int BW = WIDTH + 3;
    localparam int CW = $clog2(WIDTH / 2 + 2);
    localparam logic [CW-1:0] LAST_S = CW'(WIDTH / 2 - 1);
    localparam logic [CW-1:0] LAST_U = CW'(WIDTH / 2);

    typedef enum logic [2:0] {IDLE, POP, LOAD, EXEC, WRITE, DONE} state_t;
    state_t state, state_nxt;

    logic [HW-1:0]      mcand;
    logic [BW-1:0]      booth;
    logic [AW-1:0]      acc;
    logic [CW-1:0]      cnt;
    logic               sgn;
    logic [HW-1:0]      pp;
    logic [HW-1:0]      hi_sum;
    logic [AW-1:0]      acc_shift;
    logic [2*WIDTH-1:0] result;
    logic               last;
    logic               zero_skip;

`ifdef MUL_ZERO_SKIP_EN
    assign zero_skip = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_skip = 1'b0;
`endif

    always_comb begin
        pp = '0;
        case (booth[2:0])
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
    end

    // Lower half is WIDTH+2 bits so the unsigned extra step leaves the product exactly at bit 0.
    assign hi_sum    = acc[AW-1:LW] + pp;
    assign acc_shift = $signed({hi_sum, acc[LW-1:0]}) >>> 2;
    assign result    = sgn ? acc_shift[2*WIDTH+1:2] : acc_shift[2*WIDTH-1:0];
    assign last      = cnt == (sgn ? LAST_S : LAST_U);
    assign op_done   = state == DONE;

    always_comb begin
        state_nxt = state;
        fifo_re   = 1'b0;
        fifo_we   = 1'b0;
        case (state)
            IDLE:  state_nxt = op_start ? POP : IDLE;
            POP: begin
                if (fifo_count0 == '0 || fifo_count1 == '0) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = LOAD;
                    fifo_re   = 1'b1;
                end
            end
            LOAD:  state_nxt = zero_skip ? WRITE : EXEC;
            EXEC:  state_nxt = last ? WRITE : EXEC;
            WRITE: begin
                if (!out_full) begin
                    fifo_we   = 1'b1;
                    state_nxt = POP;
                end
            end
            default: state_nxt = state;
        endcase
        if (op_clear) begin
            state_nxt = IDLE;
            fifo_re   = 1'b0;
            fifo_we   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand      <= '0;
            booth      <= '0;
            acc        <= '0;
            cnt        <= '0;
            sgn        <= 1'b0;
            din_result <= '0;
            op_err     <= 1'b0;
        end else if (op_clear) begin
            acc        <= '0;
            cnt        <= '0;
            din_result <= '0;
            op_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    acc <= '0;
                    cnt <= '0;
                end
                POP: if ((fifo_count0 == '0) != (fifo_count1 == '0)) op_err <= 1'b1;
                LOAD: begin
                    mcand <= signed_mode ? {{3{multiplicand[WIDTH-1]}}, multiplicand}
                                         : {3'b000, multiplicand};
                    booth <= {signed_mode ? {2{multiplier[WIDTH-1]}} : 2'b00, multiplier, 1'b0};
                    sgn   <= signed_mode;
                    acc   <= '0;
                    cnt   <= '0;
                    if (zero_skip) din_result <= '0;
                end
                EXEC: begin
                    acc   <= acc_shift;
                    booth <= $signed(booth) >>> 2;
                    cnt   <= cnt + 1'b1;
                    if (last) din_result <= result;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_booth4_mul_engine.sv
// tb_booth4_mul_engine: randomized and directed checks of booth4_mul_engine against a plain-arithmetic model.
// Includes a WIDTH=8 instance for the zero-operand latency case (MUL_ZERO_SKIP_EN aware).
module tb_booth4_mul_engine;
    logic        clk = 1'b0;
    logic        reset_n, op_start, op_clear, signed_mode, out_full;
    logic [3:0]  fifo_count0 = '0, fifo_count1 = '0;
    logic [15:0] multiplicand = '0, multiplier = '0;
    logic        fifo_re, fifo_we, op_done, op_err;
    logic [31:0] din_result;

    logic        op_start8;
    logic [3:0]  c0_8, c1_8;
    logic [7:0]  a8, b8;
    logic        re8, we8, done8, err8;
    logic [15:0] din8;

    int n_chk = 0, n_err = 0;
    int cyc = 0, re_n = 0, we_n = 0, re_cyc = 0, we_cyc = 0, bad_we = 0;
    logic [15:0] q0[$], q1[$];
    logic [31:0] expq[$], got[$];
    bit pop_pend = 1'b0;

    always #5 clk = ~clk;

    booth4_mul_engine #(.WIDTH(16), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
        .signed_mode(signed_mode), .fifo_count0(fifo_count0), .fifo_count1(fifo_count1),
        .out_full(out_full), .multiplicand(multiplicand), .multiplier(multiplier),
        .fifo_re(fifo_re), .fifo_we(fifo_we), .din_result(din_result),
        .op_done(op_done), .op_err(op_err)
    );

    booth4_mul_engine #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .reset_n(reset_n), .op_start(op_start8), .op_clear(op_clear),
        .signed_mode(signed_mode), .fifo_count0(c0_8), .fifo_count1(c1_8),
        .out_full(out_full), .multiplicand(a8), .multiplier(b8),
        .fifo_re(re8), .fifo_we(we8), .din_result(din8),
        .op_done(done8), .op_err(err8)
    );

    // Pops and pushes are observed on the rising edge; FIFO data and counts move on the falling edge.
    always @(posedge clk) begin
        cyc++;
        if (fifo_re) begin
            pop_pend = 1'b1;
            re_n++;
            re_cyc = cyc;
        end
        if (fifo_we) begin
            got.push_back(din_result);
            we_n++;
            we_cyc = cyc;
            if (out_full) bad_we++;
        end
    end

    always @(negedge clk) begin
        if (pop_pend) begin
            pop_pend = 1'b0;
            if (q0.size() > 0) multiplicand = q0.pop_front();
            if (q1.size() > 0) multiplier = q1.pop_front();
        end
        fifo_count0 = 4'(q0.size());
        fifo_count1 = 4'(q1.size());
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input bit s);
        logic signed [31:0] sa, sb;
        sa = s ? {{16{a[15]}}, a} : {16'h0, a};
        sb = s ? {{16{b[15]}}, b} : {16'h0, b};
        return 32'(sa * sb);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input bit s);
        q0.push_back(a);
        q1.push_back(b);
        expq.push_back(model(a, b, s));
    endtask

    task automatic start();
        @(negedge clk);
        @(negedge clk);
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
    endtask

    task automatic clear();
        @(negedge clk);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k = 0;
        while (!op_done && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, 64'(op_done), 64'd1);
    endtask

    task automatic wait_pops(input string tag, input int target, input int bound);
        int k = 0;
        while (re_n < target && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_pops"}, 64'(re_n), 64'(target));
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_count"}, 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s_p%0d", tag, i), (i < got.size()) ? {32'h0, got[i]} : 64'hx, {32'h0, expq[i]});
        got.delete();
        expq.delete();
    endtask

    task automatic run(input string tag);
        start();
        wait_done(tag, 400);
        chk({tag, "_err"}, 64'(op_err), 64'd0);
        check_results(tag);
        clear();
    endtask

    initial begin
        int r0, w0, k, lat;
        logic [31:0] held;
        reset_n = 1'b0; op_start = 1'b0; op_clear = 1'b0; signed_mode = 1'b1; out_full = 1'b0;
        op_start8 = 1'b0; c0_8 = '0; c1_8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {27'h0, fifo_re, fifo_we, op_done, op_err, din_result}, 64'h0);
        reset_n = 1'b1;

        // Single signed pair: 3 x -5, 11-cycle pair latency (pop edge to push edge is 10 cycles).
        push(16'd3, 16'hFFFB, 1'b1);
        start();
        wait_done("t1", 100);
        chk("t1_value", got.size() > 0 ? {32'h0, got[0]} : 64'hx, 64'hFFFF_FFF1);
        chk("t1_latency", 64'(we_cyc - re_cyc), 64'd10);
        chk("t1_err", 64'(op_err), 64'd0);
        check_results("t1");
        clear();
        chk("t1_cleared", 64'(op_done), 64'd0);

        push(16'h8000, 16'h8000, 1'b1);
        start();
        wait_done("t2s", 100);
        chk("t2s_value", got.size() > 0 ? {32'h0, got[0]} : 64'hx, 64'h4000_0000);
        check_results("t2s");
        clear();

        signed_mode = 1'b0;
        push(16'hFFFF, 16'hFFFF, 1'b0);
        start();
        wait_done("t2u", 100);
        chk("t2u_value", got.size() > 0 ? {32'h0, got[0]} : 64'hx, 64'hFFFE_0001);
        chk("t2u_latency", 64'(we_cyc - re_cyc), 64'd11);
        check_results("t2u");
        clear();

        signed_mode = 1'b1;
        push(16'h7FFF, 16'h8000, 1'b1);
        for (int i = 0; i < 9; i++) push(16'($urandom), 16'($urandom), 1'b1);
        run("rand_s");
        signed_mode = 1'b0;
        push(16'h8000, 16'h7FFF, 1'b0);
        for (int i = 0; i < 9; i++) push(16'($urandom), 16'($urandom), 1'b0);
        run("rand_u");

        // Back-pressure on the first write of three.
        signed_mode = 1'b1;
        for (int i = 0; i < 3; i++) push(16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)), 1'b1);
        out_full = 1'b1;
        r0 = re_n;
        start();
        wait_pops("stall", r0 + 1, 50);
        repeat (9) @(negedge clk);
        held = din_result;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_we%0d", i), 64'(fifo_we), 64'd0);
            chk($sformatf("stall_din%0d", i), {32'h0, din_result}, {32'h0, held});
            @(negedge clk);
        end
        out_full = 1'b0;
        chk("stall_held_value", {32'h0, held}, {32'h0, expq[0]});
        wait_done("stall", 200);
        chk("stall_bad_we", 64'(bad_we), 64'd0);
        check_results("stall");
        clear();

        // Operand FIFO count mismatch.
        q0.push_back(16'd7);
        q0.push_back(16'd9);
        r0 = re_n;
        start();
        wait_done("mis", 50);
        chk("mis_no_pop", 64'(re_n), 64'(r0));
        chk("mis_err", 64'(op_err), 64'd1);
        clear();
        chk("mis_err_clr", 64'(op_err), 64'd0);
        chk("mis_done_clr", 64'(op_done), 64'd0);
        q0.delete();

        // Abort during the fourth EXEC step of the second pair.
        push(16'd1234, 16'hFFB3, 1'b1);
        push(16'd321, 16'd999, 1'b1);
        r0 = re_n;
        w0 = we_n;
        start();
        wait_pops("abort", r0 + 2, 100);
        chk("abort_first_din", {32'h0, din_result}, {32'h0, expq[0]});
        repeat (4) @(negedge clk);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
        chk("abort_din", {32'h0, din_result}, 64'h0);
        chk("abort_done", 64'(op_done), 64'd0);
        repeat (15) @(negedge clk);
        chk("abort_we", 64'(we_n - w0), 64'd1);
        chk("abort_idle", 64'(re_n), 64'(r0 + 2));
        void'(expq.pop_back());
        check_results("abort");

        // Asynchronous reset while stalled in WRITE.
        push(16'd100, 16'd200, 1'b1);
        out_full = 1'b1;
        r0 = re_n;
        start();
        wait_pops("rst", r0 + 1, 50);
        repeat (9) @(negedge clk);
        chk("rst_pre_din", {32'h0, din_result}, {32'h0, expq[0]});
        w0 = we_n;
        reset_n = 1'b0;
        #1;
        chk("rst_outs", {27'h0, fifo_re, fifo_we, op_done, op_err, din_result}, 64'h0);
        @(negedge clk);
        out_full = 1'b0;
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("rst_no_push", 64'(we_n), 64'(w0));
        got.delete();
        expq.delete();

        // WIDTH=8 zero operand: 0 x 123, signed.
        c0_8 = 4'd1;
        c1_8 = 4'd1;
        @(negedge clk);
        op_start8 = 1'b1;
        @(negedge clk);
        op_start8 = 1'b0;
        k = 0;
        while (!re8 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("w8_pop", 64'(re8), 64'd1);
        a8 = 8'd0;
        b8 = 8'd123;
        lat = 0;
        while (!we8 && lat < 30) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                c0_8 = '0;
                c1_8 = '0;
            end
        end
`ifdef MUL_ZERO_SKIP_EN
        chk("w8_latency", 64'(lat), 64'd2);
`else
        chk("w8_latency", 64'(lat), 64'd6);
`endif
        chk("w8_din", {48'h0, din8}, 64'h0);
        k = 0;
        while (!done8 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("w8_done", 64'(done8), 64'd1);
        chk("w8_err", 64'(err8), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
